// File: rtl/rr_index_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_index_arbiter_pkg
// Types and helpers shared by the round-robin index arbiter and any later
// arbiters built on the same pointer scheme.
//   rr_state_t   : handshake FSM state (IDLE = no index offered,
//                  HOLD = index offered and frozen until it is accepted)
//   rr_wrap_inc  : modulo-n increment of a requester index
// ---------------------------------------------------------------------------
package rr_index_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rr_state_t;

    // The sum is formed in a 32-bit value, which is always wider than the
    // index. The wrap therefore comes from the explicit compare against n.
    // It does not come from overflow, so a non-power-of-two n wraps correctly.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                                input int unsigned n);
        int unsigned sum;
        sum = idx + 32'd1;
        return (sum >= n) ? 32'd0 : sum;
    endfunction

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin pick. It returns the first requester at or
// after the pointer, scanning upward modulo NUM_REQ.
//   i_req   [NUM_REQ] : request vector, bit k = requester k wants a grant
//   i_ptr   [IDX_W]   : requester with highest priority this cycle
//   o_idx   [IDX_W]   : winning requester index (0 when nothing is found)
//   o_found           : a winner exists
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [2*NUM_REQ-1:0] w_reqDouble;
    logic [NUM_REQ-1:0]   w_rotated;

    // Concatenating the vector with itself and shifting right by the pointer
    // puts requester ptr at bit 0, ptr+1 at bit 1, and so on. The wrap-around
    // is then an ordinary fixed-priority scan from bit 0.
    assign w_reqDouble = {i_req, i_req};
    assign w_rotated   = NUM_REQ'(w_reqDouble >> i_ptr);

    // Scan downward so the lowest rotated position is written last and wins.
    // The rotated position is mapped back to an absolute index with a compare
    // against NUM_REQ instead of a power-of-two mask.
    always_comb begin
        int unsigned pos;
        o_idx   = '0;
        o_found = 1'b0;
        pos     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                pos = 32'(i_ptr) + 32'(k);
                if (pos >= 32'(NUM_REQ)) begin
                    pos = pos - 32'(NUM_REQ);
                end
                o_idx   = IDX_W'(pos);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// ---------------------------------------------------------------------------
// rr_index_arbiter
// Round-robin arbiter. It presents the winning requester as a registered binary
// index with a valid/ready handshake. The index is held stable until it is
// accepted. The downstream one-hot decoder uses gnt_idx_o as its address and
// gnt_valid_o as its address-valid input.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   req_i        [NUM_REQ] : request vector
//   gnt_idx_o    [IDX_W]   : winning index (registered)
//   gnt_valid_o            : index valid (registered)
//   gnt_ready_i            : consumer accepts the index when high with valid
// ---------------------------------------------------------------------------
module rr_index_arbiter
    import rr_index_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i
);

    rr_state_t          r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gntIdx;
    logic               r_gntValid;

    rr_state_t          w_stateNext;
    logic [IDX_W-1:0]   w_ptrNext;
    logic [IDX_W-1:0]   w_idxNext;
    logic               w_validNext;

    logic               w_handshake;
    logic [IDX_W-1:0]   w_incPtr;
    logic [IDX_W-1:0]   w_pickPtr;
    logic [IDX_W-1:0]   w_pickIdx;
    logic               w_pickFound;

    assign w_handshake = r_gntValid & gnt_ready_i;

    // Pointer value that takes effect once the current index is accepted.
    assign w_incPtr = IDX_W'(rr_wrap_inc(32'(r_gntIdx), 32'(NUM_REQ)));

    // On a handshake the same-cycle re-arbitration must already use the
    // advanced pointer. Otherwise the just-served requester could win again
    // ahead of its neighbours.
    assign w_pickPtr = w_handshake ? w_incPtr : r_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req_i),
        .i_ptr   (w_pickPtr),
        .o_idx   (w_pickIdx),
        .o_found (w_pickFound)
    );

    // Next-state logic. In HOLD without a handshake everything stays frozen,
    // even if the granted request drops. The default assignments cover that.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_idxNext   = r_gntIdx;
        w_validNext = r_gntValid;
        case (r_state)
            IDLE: begin
                w_validNext = 1'b0;
                if (w_pickFound) begin
                    w_idxNext   = w_pickIdx;
                    w_validNext = 1'b1;
                    w_stateNext = HOLD;
                end
            end
            HOLD: begin
                if (w_handshake) begin
                    w_ptrNext = w_incPtr;
                    if (w_pickFound) begin
                        w_idxNext   = w_pickIdx;
                        w_validNext = 1'b1;
                    end else begin
                        w_validNext = 1'b0;
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_validNext = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers. Reset wins over any pending
    // handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gntIdx   <= '0;
            r_gntValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_ptr      <= w_ptrNext;
            r_gntIdx   <= w_idxNext;
            r_gntValid <= w_validNext;
        end
    end

    assign gnt_idx_o   = r_gntIdx;
    assign gnt_valid_o = r_gntValid;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_index_arbiter
// Directed test of rr_index_arbiter. A 4-requester instance exercises reset,
// rotation, backpressure, drain and reset mid-handshake. A 5-requester
// instance exercises the non-power-of-two wrap.
// ---------------------------------------------------------------------------
module tb_rr_index_arbiter;

    logic       clk;
    logic       rst;
    logic       ready;
    logic [3:0] req4;
    logic [4:0] req5;
    logic [1:0] idx4;
    logic       valid4;
    logic [2:0] idx5;
    logic       valid5;

    int total = 0;
    int bad   = 0;

    rr_index_arbiter #(.NUM_REQ(4)) dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req4),
        .gnt_idx_o   (idx4),
        .gnt_valid_o (valid4),
        .gnt_ready_i (ready)
    );

    rr_index_arbiter #(.NUM_REQ(5)) dut5 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req5),
        .gnt_idx_o   (idx5),
        .gnt_valid_o (valid5),
        .gnt_ready_i (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before outputs are sampled.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        req4  = 4'b1111;
        req5  = 5'b00000;

        // Reset held for three edges with every requester active.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("reset_valid", 8'(valid4), 8'd0);
            checkOutput("reset_idx",   8'(idx4),   8'd0);
        end

        // First grant after release comes from pointer 0.
        rst = 1'b0;
        applyStimulus();
        checkOutput("first_valid", 8'(valid4), 8'd1);
        checkOutput("first_idx",   8'(idx4),   8'd0);

        // Rotation with ready held high: 1,2,3,0 follow the initial 0.
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput("rot_valid", 8'(valid4), 8'd1);
            checkOutput("rot_idx",   8'(idx4),   8'(i % 4));
        end

        // Accept index 0. Only requester 2 remains, so index 2 is offered.
        req4 = 4'b0100;
        applyStimulus();
        checkOutput("bp_setup_idx", 8'(idx4), 8'd2);

        // Backpressure holds index 2 while requests change underneath it.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req4 = 4'b1001;
            applyStimulus();
            checkOutput("bp_hold_valid", 8'(valid4), 8'd1);
            checkOutput("bp_hold_idx",   8'(idx4),   8'd2);
        end

        // Accept index 2. The pointer moves to 3, and requester 3 wins over 0.
        ready = 1'b1;
        applyStimulus();
        checkOutput("bp_next_idx", 8'(idx4), 8'd3);

        // Accept index 3 with no requests pending. The arbiter drains to idle
        // and the pointer wraps to 0.
        req4 = 4'b0000;
        applyStimulus();
        checkOutput("drain0_valid", 8'(valid4), 8'd0);

        // Pulse requester 1 for a single cycle.
        req4 = 4'b0010;
        applyStimulus();
        checkOutput("pulse_valid", 8'(valid4), 8'd1);
        checkOutput("pulse_idx",   8'(idx4),   8'd1);
        req4 = 4'b0000;
        applyStimulus();
        checkOutput("drain1_valid", 8'(valid4), 8'd0);
        applyStimulus();
        checkOutput("drain2_valid", 8'(valid4), 8'd0);

        // Pointer is now 2, and ready during idle does not move it. With all
        // requesters active, index 2 wins.
        ready = 1'b0;
        req4  = 4'b1111;
        applyStimulus();
        checkOutput("ptr2_valid", 8'(valid4), 8'd1);
        checkOutput("ptr2_idx",   8'(idx4),   8'd2);

        // Reset in the same cycle as a handshake.
        ready = 1'b1;
        rst   = 1'b1;
        applyStimulus();
        checkOutput("rst_hs_valid", 8'(valid4), 8'd0);
        checkOutput("rst_hs_idx",   8'(idx4),   8'd0);
        checkOutput("rst_hs_valid5", 8'(valid5), 8'd0);

        // After reset the pointer is 0 again, so index 0 wins.
        rst   = 1'b0;
        ready = 1'b0;
        applyStimulus();
        checkOutput("post_rst_idx", 8'(idx4), 8'd0);

        // Non-power-of-two wrap: requesters 0 and 4 alternate, and the index
        // never goes past 4.
        ready = 1'b1;
        req5  = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("wrap5_valid", 8'(valid5), 8'd1);
            checkOutput("wrap5_idx",   8'(idx5),   (i % 2 == 0) ? 8'd0 : 8'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
